// File: rtl/crc_decoder.sv
// ---------------------------------------------------------------------------
// crc_decoder
//
// Serial USB packet receiver. Takes de-stuffed, NRZI-decoded bits (LSB-first
// per field), validates the PID check nibble and the CRC5/CRC16 residual, and
// presents one decoded packet record at a time over a valid/ready handshake.
//
// Optional feature macro: RX_PID_CHECK_EN
//   defined   : PID bits [7:4] must equal ~PID[3:0], a mismatch reports err 01
//   undefined : PID bits [7:4] are ignored, err 01 is never produced
//
// Ports
//   clk        in   clock
//   rst_b      in   asynchronous active-low reset
//   bit_in     in   serial packet bit
//   bit_valid  in   bit_in carries a packet bit this cycle
//   eop        in   end-of-packet pulse (after the last valid bit)
//   out_valid  out  record held for the consumer
//   out_ready  in   consumer accepts the record
//   pkt_type   out  00 none, 01 token, 10 data, 11 handshake
//   pid        out  received PID[3:0]
//   addr_endp  out  token field {endp, addr}
//   data       out  data payload, first-received bit in data[0]
//   err        out  00 ok, 01 PID check, 10 CRC, 11 length
//   overrun    out  pulse: a packet arrived while the record was held
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for the first bit of a packet
// S_PID   | collecting the 8-bit PID byte
// S_TOKEN | 11 token field bits + 5 CRC5 bits
// S_DATA  | 64 payload bits + 16 CRC16 bits
// S_HSK   | handshake, no bits expected after the PID
// S_SKIP  | unknown PID, remaining bits ignored until eop
// S_HOLD  | record presented, waiting for out_ready
// ---------------------------------------------------------------------------
module crc_decoder (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        bit_in,
    input  logic        bit_valid,
    input  logic        eop,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [1:0]  pkt_type,
    output logic [3:0]  pid,
    output logic [10:0] addr_endp,
    output logic [63:0] data,
    output logic [1:0]  err,
    output logic        overrun
);

    typedef enum logic [2:0] {
        S_IDLE, S_PID, S_TOKEN, S_DATA, S_HSK, S_SKIP, S_HOLD
    } state_t;

    localparam logic [6:0]  TOK_BITS  = 7'd16;
    localparam logic [6:0]  TOK_FIELD = 7'd11;
    localparam logic [6:0]  DAT_BITS  = 7'd80;
    localparam logic [6:0]  DAT_FIELD = 7'd64;
    localparam logic [4:0]  CRC5_RES  = 5'b01100;
    localparam logic [15:0] CRC16_RES = 16'h800D;

    function automatic state_t pid_class(input logic [3:0] p);
        state_t s;
        case (p)
            4'b0001, 4'b1001, 4'b1101: s = S_TOKEN;
            4'b0011, 4'b1011:          s = S_DATA;
            4'b0010, 4'b1010, 4'b1110: s = S_HSK;
            default:                   s = S_SKIP;
        endcase
        return s;
    endfunction

    function automatic logic [4:0] crc5_step(input logic [4:0] c, input logic b);
        logic fb;
        fb = b ^ c[4];
        return {c[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
    endfunction

    function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
        logic fb;
        fb = b ^ c[15];
        return {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
    endfunction

    state_t      r_state;
    logic [6:0]  r_cnt;
    logic [7:0]  r_pid_byte;
    logic [10:0] r_tok;
    logic [63:0] r_data_sh;
    logic [4:0]  r_crc5;
    logic [15:0] r_crc16;
    logic        r_len_err;
    logic        r_pid_bad;
    logic        r_drop;

    logic        r_out_valid;
    logic [1:0]  r_pkt_type;
    logic [3:0]  r_pid;
    logic [10:0] r_addr_endp;
    logic [63:0] r_data;
    logic [1:0]  r_err;
    logic        r_overrun;

    // Working state after consuming this cycle's bit; eop is judged on these
    // so a bit coincident with eop counts toward the packet.
    state_t      w_state_a;
    logic [6:0]  w_cnt_a;
    logic [7:0]  w_pid_a;
    logic [10:0] w_tok_a;
    logic [63:0] w_data_a;
    logic [4:0]  w_crc5_a;
    logic [15:0] w_crc16_a;
    logic        w_len_a;
    logic        w_pbad_a;

    logic        w_eop_take;
    logic [1:0]  w_rec_type;
    logic [10:0] w_rec_ae;
    logic [63:0] w_rec_data;
    logic [1:0]  w_rec_err;

    always_comb begin
        w_state_a = r_state;
        w_cnt_a   = r_cnt;
        w_pid_a   = r_pid_byte;
        w_tok_a   = r_tok;
        w_data_a  = r_data_sh;
        w_crc5_a  = r_crc5;
        w_crc16_a = r_crc16;
        w_len_a   = r_len_err;
        w_pbad_a  = r_pid_bad;
        if (bit_valid && !r_drop) begin
            case (r_state)
                S_IDLE: begin
                    w_state_a = S_PID;
                    w_pid_a   = {7'd0, bit_in};
                    w_cnt_a   = 7'd1;
                    w_tok_a   = '0;
                    w_data_a  = '0;
                    w_crc5_a  = 5'h1F;
                    w_crc16_a = 16'hFFFF;
                    w_len_a   = 1'b0;
                    w_pbad_a  = 1'b0;
                end
                S_PID: begin
                    w_pid_a[r_cnt[2:0]] = bit_in;
                    if (r_cnt == 7'd7) begin
                        w_state_a = pid_class(w_pid_a[3:0]);
                        w_cnt_a   = 7'd0;
`ifdef RX_PID_CHECK_EN
                        w_pbad_a  = (w_pid_a[7:4] != ~w_pid_a[3:0]);
`else
                        w_pbad_a  = 1'b0;
`endif
                    end else begin
                        w_cnt_a = r_cnt + 7'd1;
                    end
                end
                S_TOKEN: begin
                    if (r_cnt < TOK_BITS) begin
                        w_crc5_a = crc5_step(r_crc5, bit_in);
                        // Shift in from the top so the first field bit ends at [0].
                        if (r_cnt < TOK_FIELD)
                            w_tok_a = {bit_in, r_tok[10:1]};
                        w_cnt_a = r_cnt + 7'd1;
                    end else begin
                        w_len_a = 1'b1;
                    end
                end
                S_DATA: begin
                    if (r_cnt < DAT_BITS) begin
                        w_crc16_a = crc16_step(r_crc16, bit_in);
                        if (r_cnt < DAT_FIELD)
                            w_data_a = {bit_in, r_data_sh[63:1]};
                        w_cnt_a = r_cnt + 7'd1;
                    end else begin
                        w_len_a = 1'b1;
                    end
                end
                S_HSK:   w_len_a = 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        w_rec_type = 2'b00;
        w_rec_ae   = '0;
        w_rec_data = '0;
        w_rec_err  = 2'b11;
        case (w_state_a)
            S_TOKEN: begin
                w_rec_type = 2'b01;
                w_rec_ae   = w_tok_a;
                if (w_len_a || (w_cnt_a != TOK_BITS)) w_rec_err = 2'b11;
                else if (w_pbad_a)                    w_rec_err = 2'b01;
                else if (w_crc5_a != CRC5_RES)        w_rec_err = 2'b10;
                else                                  w_rec_err = 2'b00;
            end
            S_DATA: begin
                w_rec_type = 2'b10;
                w_rec_data = w_data_a;
                if (w_len_a || (w_cnt_a != DAT_BITS)) w_rec_err = 2'b11;
                else if (w_pbad_a)                    w_rec_err = 2'b01;
                else if (w_crc16_a != CRC16_RES)      w_rec_err = 2'b10;
                else                                  w_rec_err = 2'b00;
            end
            S_HSK: begin
                w_rec_type = 2'b11;
                if (w_len_a)       w_rec_err = 2'b11;
                else if (w_pbad_a) w_rec_err = 2'b01;
                else               w_rec_err = 2'b00;
            end
            default: ;
        endcase
    end

    assign w_eop_take = eop && !r_drop && (w_state_a != S_IDLE) && (w_state_a != S_HOLD);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_pid_byte  <= '0;
            r_tok       <= '0;
            r_data_sh   <= '0;
            r_crc5      <= '0;
            r_crc16     <= '0;
            r_len_err   <= 1'b0;
            r_pid_bad   <= 1'b0;
            r_drop      <= 1'b0;
            r_out_valid <= 1'b0;
            r_pkt_type  <= '0;
            r_pid       <= '0;
            r_addr_endp <= '0;
            r_data      <= '0;
            r_err       <= '0;
            r_overrun   <= 1'b0;
        end else begin
            r_overrun <= (r_state == S_HOLD) && bit_valid && !r_drop;

            // A packet that starts while the record is held is discarded
            // through its eop, even if the record is accepted meanwhile.
            if (r_drop) begin
                if (eop) r_drop <= 1'b0;
            end else if ((r_state == S_HOLD) && bit_valid && !eop) begin
                r_drop <= 1'b1;
            end

            if (r_state == S_HOLD) begin
                if (out_ready) begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                end
            end else begin
                r_state    <= w_state_a;
                r_cnt      <= w_cnt_a;
                r_pid_byte <= w_pid_a;
                r_tok      <= w_tok_a;
                r_data_sh  <= w_data_a;
                r_crc5     <= w_crc5_a;
                r_crc16    <= w_crc16_a;
                r_len_err  <= w_len_a;
                r_pid_bad  <= w_pbad_a;
                if (w_eop_take) begin
                    r_state     <= S_HOLD;
                    r_out_valid <= 1'b1;
                    r_pkt_type  <= w_rec_type;
                    r_pid       <= w_pid_a[3:0];
                    r_addr_endp <= w_rec_ae;
                    r_data      <= w_rec_data;
                    r_err       <= w_rec_err;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign pkt_type  = r_pkt_type;
    assign pid       = r_pid;
    assign addr_endp = r_addr_endp;
    assign data      = r_data;
    assign err       = r_err;
    assign overrun   = r_overrun;

endmodule
